// File: rtl/ysyx_25010008_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_25010008_axi_arbiter
//
// Two-master to one-slave AXI4-Lite arbiter. The IFU (read-only) and the LSU
// (read + write) share one outbound port towards the Xbar/memory. Only one
// transaction is outstanding at a time: an IDLE-state decision registers a
// grant, the granted master's channels are then passed through
// combinationally, and the grant is held until that transaction's final
// response handshake (r for reads, b for writes).
//
// Ports
//   clock, reset        system clock; synchronous active-high reset
//   ifu_ar*, ifu_r*     IFU read address / read data channels (slave side)
//   lsu_ar*, lsu_r*     LSU read address / read data channels (slave side)
//   lsu_aw*, lsu_w*,
//   lsu_b*              LSU write address / data / response (slave side)
//   out_*               outbound AXI4-Lite master port (all five channels)
//
// Configuration macro
//   ARB_ROUND_ROBIN_EN  when defined, a 1-bit last-grant register breaks
//                       IFU/LSU ties in favour of the master not granted
//                       last; when undefined, fixed priority LSU > IFU.
//                       LSU read still beats LSU write in both builds.
// ---------------------------------------------------------------------------
module ysyx_25010008_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  // IFU read channels
  input  logic [ADDR_W-1:0]     ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // LSU read channels
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  // LSU write channels
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic                  lsu_awvalid,
  output logic                  lsu_awready,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_wready,
  output logic [1:0]            lsu_bresp,
  output logic                  lsu_bvalid,
  input  logic                  lsu_bready,
  // Outbound master port
  output logic [ADDR_W-1:0]     out_araddr,
  output logic                  out_arvalid,
  input  logic                  out_arready,
  input  logic [DATA_W-1:0]     out_rdata,
  input  logic [1:0]            out_rresp,
  input  logic                  out_rvalid,
  output logic                  out_rready,
  output logic [ADDR_W-1:0]     out_awaddr,
  output logic                  out_awvalid,
  input  logic                  out_awready,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [DATA_W/8-1:0]   out_wstrb,
  output logic                  out_wvalid,
  input  logic                  out_wready,
  input  logic [1:0]            out_bresp,
  input  logic                  out_bvalid,
  output logic                  out_bready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  state_t state;
  logic   lsu_req;
  logic   lsu_wins;

  assign lsu_req = lsu_arvalid || lsu_awvalid;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = the LSU held the most recent grant. On an IFU/LSU tie the other
  // master wins, so neither can starve the other.
  logic last_lsu;
  assign lsu_wins = lsu_req && (!ifu_arvalid || !last_lsu);
`else
  assign lsu_wins = lsu_req;
`endif

  // Grant FSM. The decision is registered, so pass-through begins the cycle
  // after a request is first seen, and every release is followed by at least
  // one IDLE cycle before the next grant.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the update order inside the block is
  // irrelevant.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_lsu <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (lsu_wins) begin
            // A simultaneous LSU read and write: the read goes first, the
            // write stays pending and is picked up by a later decision.
            state <= lsu_arvalid ? LSU_RD : LSU_WR;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu <= 1'b1;
`endif
          end else if (ifu_arvalid) begin
            state <= IFU_RD;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu <= 1'b0;
`endif
          end
        end
        IFU_RD, LSU_RD: if (out_rvalid && out_rready) state <= IDLE;
        LSU_WR:         if (out_bvalid && out_bready) state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  // Channel routing. Everything not owned by the current grant is held at 0,
  // which also keeps any response offered in IDLE un-accepted.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    out_araddr  = '0;
    out_arvalid = 1'b0;
    out_rready  = 1'b0;
    out_awaddr  = '0;
    out_awvalid = 1'b0;
    out_wdata   = '0;
    out_wstrb   = '0;
    out_wvalid  = 1'b0;
    out_bready  = 1'b0;

    unique case (state)
      IFU_RD: begin
        out_araddr  = ifu_araddr;
        out_arvalid = ifu_arvalid;
        ifu_arready = out_arready;
        ifu_rdata   = out_rdata;
        ifu_rresp   = out_rresp;
        ifu_rvalid  = out_rvalid;
        out_rready  = ifu_rready;
      end
      LSU_RD: begin
        out_araddr  = lsu_araddr;
        out_arvalid = lsu_arvalid;
        lsu_arready = out_arready;
        lsu_rdata   = out_rdata;
        lsu_rresp   = out_rresp;
        lsu_rvalid  = out_rvalid;
        out_rready  = lsu_rready;
      end
      LSU_WR: begin
        // aw and w are forwarded independently; the LSU sequences them.
        out_awaddr  = lsu_awaddr;
        out_awvalid = lsu_awvalid;
        lsu_awready = out_awready;
        out_wdata   = lsu_wdata;
        out_wstrb   = lsu_wstrb;
        out_wvalid  = lsu_wvalid;
        lsu_wready  = out_wready;
        lsu_bresp   = out_bresp;
        lsu_bvalid  = out_bvalid;
        out_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25010008_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25010008_axi_arbiter
//
// Bench for the two-master AXI4-Lite arbiter. A behavioural slave answers on
// the out_* port (read data derived from the address, configurable latency
// and response codes, optional withheld b response). Master-side tasks drive
// the IFU/LSU channels; expected responses are queued per master when a
// request is issued and popped when the response arrives. Inputs change on
// the falling edge and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_ysyx_25010008_axi_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 50;

  logic                clock;
  logic                reset;
  logic [ADDR_W-1:0]   ifu_araddr;
  logic                ifu_arvalid;
  logic                ifu_arready;
  logic [DATA_W-1:0]   ifu_rdata;
  logic [1:0]          ifu_rresp;
  logic                ifu_rvalid;
  logic                ifu_rready;
  logic [ADDR_W-1:0]   lsu_araddr;
  logic                lsu_arvalid;
  logic                lsu_arready;
  logic [DATA_W-1:0]   lsu_rdata;
  logic [1:0]          lsu_rresp;
  logic                lsu_rvalid;
  logic                lsu_rready;
  logic [ADDR_W-1:0]   lsu_awaddr;
  logic                lsu_awvalid;
  logic                lsu_awready;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wstrb;
  logic                lsu_wvalid;
  logic                lsu_wready;
  logic [1:0]          lsu_bresp;
  logic                lsu_bvalid;
  logic                lsu_bready;
  logic [ADDR_W-1:0]   out_araddr;
  logic                out_arvalid;
  logic                out_arready;
  logic [DATA_W-1:0]   out_rdata;
  logic [1:0]          out_rresp;
  logic                out_rvalid;
  logic                out_rready;
  logic [ADDR_W-1:0]   out_awaddr;
  logic                out_awvalid;
  logic                out_awready;
  logic [DATA_W-1:0]   out_wdata;
  logic [DATA_W/8-1:0] out_wstrb;
  logic                out_wvalid;
  logic                out_wready;
  logic [1:0]          out_bresp;
  logic                out_bvalid;
  logic                out_bready;

  ysyx_25010008_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .out_araddr(out_araddr), .out_arvalid(out_arvalid), .out_arready(out_arready),
    .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rvalid(out_rvalid), .out_rready(out_rready),
    .out_awaddr(out_awaddr), .out_awvalid(out_awvalid), .out_awready(out_awready),
    .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wvalid(out_wvalid), .out_wready(out_wready),
    .out_bresp(out_bresp), .out_bvalid(out_bvalid), .out_bready(out_bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboards: {resp, data} per read master, resp for LSU writes.
  logic [33:0] sb_ifu[$];
  logic [33:0] sb_lsu[$];
  logic [1:0]  sb_b[$];

  // ---------------- behavioural slave ----------------
  int          slv_rdelay = 2;
  logic [1:0]  slv_rresp  = 2'b00;
  logic [1:0]  slv_bresp  = 2'b00;
  bit          slv_hold_b = 1'b0;
  bit          rd_busy, aw_got, w_got, rst_seen;
  bit          hs_ar, hs_r, hs_aw, hs_w, hs_b;
  int          rd_cnt;
  logic [31:0] rd_addr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  int          bvalid_cnt = 0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hC0DE_0000);
  endfunction

  initial begin
    {rd_busy, aw_got, w_got, rst_seen, hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
    rd_cnt = 0; rd_addr = '0; cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;
    out_arready = 1'b1; out_rvalid = 1'b0; out_rdata = '0; out_rresp = '0;
    out_awready = 1'b1; out_wready = 1'b1; out_bvalid = 1'b0; out_bresp = '0;
    forever begin
      @(negedge clock);
      if (rst_seen) begin
        {rd_busy, aw_got, w_got} = '0;
        out_arready = 1'b1; out_rvalid = 1'b0; out_rdata = '0; out_rresp = '0;
        out_awready = 1'b1; out_wready = 1'b1; out_bvalid = 1'b0; out_bresp = '0;
      end else begin
        if (hs_r) begin
          out_rvalid = 1'b0; out_rdata = '0; out_rresp = '0; rd_busy = 1'b0;
        end
        if (hs_ar) begin
          rd_busy = 1'b1; rd_cnt = slv_rdelay;
        end else if (rd_busy && !out_rvalid) begin
          if (rd_cnt <= 1) begin
            out_rvalid = 1'b1; out_rdata = slave_data(rd_addr); out_rresp = slv_rresp;
          end else begin
            rd_cnt--;
          end
        end
        out_arready = !rd_busy;
        if (hs_b) begin
          out_bvalid = 1'b0; out_bresp = '0; aw_got = 1'b0; w_got = 1'b0;
        end
        if (hs_aw) aw_got = 1'b1;
        if (hs_w)  w_got  = 1'b1;
        if (aw_got && w_got && !out_bvalid && !slv_hold_b) begin
          out_bvalid = 1'b1; out_bresp = slv_bresp;
        end
        out_awready = !aw_got;
        out_wready  = !w_got;
      end
      #3;
      rst_seen = reset;
      hs_ar = out_arvalid && out_arready;
      if (hs_ar) rd_addr = out_araddr;
      hs_r  = out_rvalid && out_rready;
      hs_aw = out_awvalid && out_awready;
      if (hs_aw) cap_awaddr = out_awaddr;
      hs_w  = out_wvalid && out_wready;
      if (hs_w) begin cap_wdata = out_wdata; cap_wstrb = out_wstrb; end
      hs_b  = out_bvalid && out_bready;
      if (lsu_bvalid) bvalid_cnt++;
    end
  end

  // ---------------- master-side drivers (enter and leave on a negedge) ----
  task automatic ifu_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int ar_cyc,
                          output int r_cyc, output bit to);
    int n;
    to = 1'b0; data = '0; resp = '0; ar_cyc = -1; r_cyc = -1;
    ifu_araddr = addr; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
    n = 0; #1;
    while (!ifu_arready && n < TMO) begin @(negedge clock); #1; n++; end
    if (!ifu_arready) to = 1'b1; else ar_cyc = cyc;
    @(negedge clock);
    ifu_arvalid = 1'b0; ifu_araddr = '0;
    if (!to) begin
      n = 0; #1;
      while (!ifu_rvalid && n < TMO) begin @(negedge clock); #1; n++; end
      if (!ifu_rvalid) to = 1'b1;
      else begin data = ifu_rdata; resp = ifu_rresp; r_cyc = cyc; end
      @(negedge clock);
    end
    ifu_rready = 1'b0;
  endtask

  task automatic lsu_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int ar_cyc,
                          output int r_cyc, output bit to);
    int n;
    to = 1'b0; data = '0; resp = '0; ar_cyc = -1; r_cyc = -1;
    lsu_araddr = addr; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
    n = 0; #1;
    while (!lsu_arready && n < TMO) begin @(negedge clock); #1; n++; end
    if (!lsu_arready) to = 1'b1; else ar_cyc = cyc;
    @(negedge clock);
    lsu_arvalid = 1'b0; lsu_araddr = '0;
    if (!to) begin
      n = 0; #1;
      while (!lsu_rvalid && n < TMO) begin @(negedge clock); #1; n++; end
      if (!lsu_rvalid) to = 1'b1;
      else begin data = lsu_rdata; resp = lsu_rresp; r_cyc = cyc; end
      @(negedge clock);
    end
    lsu_rready = 1'b0;
  endtask

  task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output int aw_cyc, output int b_cyc, output bit to);
    int n;
    to = 1'b0; resp = '0; aw_cyc = -1; b_cyc = -1;
    lsu_awaddr = addr; lsu_awvalid = 1'b1; lsu_bready = 1'b1;
    n = 0; #1;
    while (!lsu_awready && n < TMO) begin @(negedge clock); #1; n++; end
    if (!lsu_awready) to = 1'b1; else aw_cyc = cyc;
    @(negedge clock);
    lsu_awvalid = 1'b0; lsu_awaddr = '0;
    if (!to) begin
      lsu_wdata = data; lsu_wstrb = strb; lsu_wvalid = 1'b1;
      n = 0; #1;
      while (!lsu_wready && n < TMO) begin @(negedge clock); #1; n++; end
      if (!lsu_wready) to = 1'b1;
      @(negedge clock);
      lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    end
    if (!to) begin
      n = 0; #1;
      while (!lsu_bvalid && n < TMO) begin @(negedge clock); #1; n++; end
      if (!lsu_bvalid) to = 1'b1;
      else begin resp = lsu_bresp; b_cyc = cyc; end
      @(negedge clock);
    end
    lsu_bready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; ifu_rready = 1'b1;
    lsu_araddr = 32'h8000_0040; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
    lsu_awaddr = '0; lsu_awvalid = 1'b1; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_wvalid = 1'b0; lsu_bready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if ({ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, lsu_arready, lsu_rvalid,
         lsu_rdata, lsu_rresp, lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
         out_araddr, out_arvalid, out_rready, out_awaddr, out_awvalid, out_wdata,
         out_wstrb, out_wvalid, out_bready} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: an output is nonzero during reset (out_arvalid=%b ifu_arready=%b lsu_arready=%b), required all 0",
               out_arvalid, ifu_arready, lsu_arready);
    end
    ifu_arvalid = 1'b0; ifu_rready = 1'b0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
    lsu_awvalid = 1'b0; lsu_bready = 1'b0; ifu_araddr = '0; lsu_araddr = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_ifu_read();
    logic [31:0] d; logic [1:0] r; int a0, r0, a1, r1, t0; bit to;
    logic [33:0] exp;
    sb_ifu.push_back({2'b00, slave_data(32'h8000_0000)});
    t0 = cyc;
    ifu_read(32'h8000_0000, d, r, a0, r0, to);
    n_checks++;
    if (to) begin n_errors++; $display("FAIL ifu_read_timeout: got timeout, required completion"); end
    exp = sb_ifu.pop_front();
    n_checks++;
    if ({r, d} !== exp) begin
      n_errors++; $display("FAIL ifu_read_data: got resp=%b data=%h, required resp=%b data=%h", r, d, exp[33:32], exp[31:0]);
    end
    n_checks++;
    if (a0 - t0 !== 1) begin
      n_errors++; $display("FAIL ifu_grant_latency: got %0d cycles, required 1", a0 - t0);
    end
    // The cycle right after the r handshake must be IDLE, even with a new request up.
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
    #1;
    n_checks++;
    if ({ifu_arready, out_arvalid, out_rready} !== 3'b000) begin
      n_errors++; $display("FAIL ifu_idle_gap: got arready/out_arvalid/out_rready=%b, required 000",
                           {ifu_arready, out_arvalid, out_rready});
    end
    sb_ifu.push_back({2'b00, slave_data(32'h8000_0004)});
    ifu_read(32'h8000_0004, d, r, a1, r1, to);
    exp = sb_ifu.pop_front();
    n_checks++;
    if (to || {r, d} !== exp) begin
      n_errors++; $display("FAIL ifu_read2_data: got to=%b resp=%b data=%h, required resp=%b data=%h", to, r, d, exp[33:32], exp[31:0]);
    end
    n_checks++;
    if (a1 - r0 !== 2) begin
      n_errors++; $display("FAIL ifu_back_to_back_gap: got %0d cycles, required 2", a1 - r0);
    end
  endtask

  task automatic test_lsu_write();
    logic [1:0] br, exp_b; int aw, bc; bit to_w;
    logic [31:0] d; logic [1:0] r; int a1, r1; bit to_i; logic [33:0] exp;
    bvalid_cnt = 0;
    sb_b.push_back(2'b00);
    sb_ifu.push_back({2'b00, slave_data(32'h8000_0008)});
    fork
      lsu_write(32'h8000_0010, 32'h0000_AB00, 4'b0010, br, aw, bc, to_w);
      ifu_read(32'h8000_0008, d, r, a1, r1, to_i);
    join
    exp_b = sb_b.pop_front();
    n_checks++;
    if (to_w || br !== exp_b) begin
      n_errors++; $display("FAIL lsu_write_bresp: got to=%b bresp=%b, required bresp=%b", to_w, br, exp_b);
    end
    n_checks++;
    if ({cap_awaddr, cap_wdata, cap_wstrb} !== {32'h8000_0010, 32'h0000_AB00, 4'b0010}) begin
      n_errors++; $display("FAIL lsu_write_out: got awaddr=%h wdata=%h wstrb=%b, required 80000010 0000ab00 0010",
                           cap_awaddr, cap_wdata, cap_wstrb);
    end
    n_checks++;
    if (bvalid_cnt !== 1) begin
      n_errors++; $display("FAIL lsu_bvalid_pulse: got %0d cycles of lsu_bvalid, required 1", bvalid_cnt);
    end
    exp = sb_ifu.pop_front();
    n_checks++;
    if (to_i || {r, d} !== exp || a1 - bc !== 2) begin
      n_errors++; $display("FAIL ifu_blocked_during_write: got to=%b data=%h gap=%0d, required data=%h gap=2",
                           to_i, d, a1 - bc, exp[31:0]);
    end
  endtask

  task automatic contend(input bit exp_lsu_first, input string tag);
    logic [31:0] di, dl; logic [1:0] ri, rl; int ai, rci, al, rcl; bit toi, tol;
    logic [33:0] ei, el;
    sb_ifu.push_back({2'b00, slave_data(32'h8000_0020)});
    sb_lsu.push_back({2'b00, slave_data(32'h8000_0200)});
    fork
      ifu_read(32'h8000_0020, di, ri, ai, rci, toi);
      lsu_read(32'h8000_0200, dl, rl, al, rcl, tol);
    join
    ei = sb_ifu.pop_front();
    el = sb_lsu.pop_front();
    n_checks++;
    if (toi || tol || {ri, di} !== ei || {rl, dl} !== el) begin
      n_errors++; $display("FAIL %s_data: got to=%b%b ifu=%h lsu=%h, required ifu=%h lsu=%h",
                           tag, toi, tol, di, dl, ei[31:0], el[31:0]);
    end
    n_checks++;
    if ((al < ai) !== exp_lsu_first) begin
      n_errors++; $display("FAIL %s_order: got lsu_first=%b, required %b", tag, al < ai, exp_lsu_first);
    end
    n_checks++;
    if ((exp_lsu_first ? ai - rcl : al - rci) !== 2) begin
      n_errors++; $display("FAIL %s_gap: got %0d cycles, required 2", tag, exp_lsu_first ? ai - rcl : al - rci);
    end
  endtask

  task automatic test_contention();
    logic [31:0] d; logic [1:0] r; int a, rc; bit to; logic [33:0] exp;
    bit second_lsu_first;
    // Last grant so far was the IFU, so the LSU wins in both builds.
    contend(1'b1, "contend1");
    sb_lsu.push_back({2'b00, slave_data(32'h8000_0300)});
    lsu_read(32'h8000_0300, d, r, a, rc, to);
    exp = sb_lsu.pop_front();
    n_checks++;
    if (to || {r, d} !== exp) begin
      n_errors++; $display("FAIL lsu_solo_read: got to=%b data=%h, required %h", to, d, exp[31:0]);
    end
`ifdef ARB_ROUND_ROBIN_EN
    second_lsu_first = 1'b0;
`else
    second_lsu_first = 1'b1;
`endif
    contend(second_lsu_first, "contend2");
  endtask

  task automatic test_lsu_rd_wr();
    logic [31:0] d; logic [1:0] r, br, eb; int a, rc, aw, bc; bit tor, tow;
    logic [33:0] exp;
    sb_lsu.push_back({2'b00, slave_data(32'h8000_0400)});
    sb_b.push_back(2'b00);
    fork
      lsu_read(32'h8000_0400, d, r, a, rc, tor);
      lsu_write(32'h8000_0404, 32'h1234_5678, 4'b1111, br, aw, bc, tow);
    join
    exp = sb_lsu.pop_front();
    eb  = sb_b.pop_front();
    n_checks++;
    if (tor || tow || {r, d} !== exp || br !== eb) begin
      n_errors++; $display("FAIL rdwr_data: got to=%b%b data=%h bresp=%b, required data=%h bresp=%b",
                           tor, tow, d, br, exp[31:0], eb);
    end
    n_checks++;
    if (aw - rc !== 2) begin
      n_errors++; $display("FAIL rdwr_order: got write grant %0d cycles after read end, required 2", aw - rc);
    end
  endtask

  task automatic test_reset_mid_write();
    int n; logic [31:0] d; logic [1:0] r; int a, rc; bit to; logic [33:0] exp;
    slv_hold_b = 1'b1;
    lsu_awaddr = 32'h8000_0500; lsu_awvalid = 1'b1; lsu_bready = 1'b1;
    n = 0; #1;
    while (!lsu_awready && n < TMO) begin @(negedge clock); #1; n++; end
    @(negedge clock);
    lsu_awvalid = 1'b0;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wvalid = 1'b1;
    n = 0; #1;
    while (!lsu_wready && n < TMO) begin @(negedge clock); #1; n++; end
    @(negedge clock);
    lsu_wvalid = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if ({out_bready, lsu_bvalid} !== 2'b10) begin
      n_errors++; $display("FAIL wr_waiting_b: got out_bready/lsu_bvalid=%b, required 10", {out_bready, lsu_bvalid});
    end
    @(negedge clock);
    reset = 1'b1; ifu_araddr = 32'h8000_0600; ifu_arvalid = 1'b1;
    @(negedge clock);
    #1;
    n_checks++;
    if ({ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, lsu_arready, lsu_rvalid,
         lsu_rdata, lsu_rresp, lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
         out_araddr, out_arvalid, out_rready, out_awaddr, out_awvalid, out_wdata,
         out_wstrb, out_wvalid, out_bready} !== '0) begin
      n_errors++; $display("FAIL reset_mid_write: got out_bready=%b out_awvalid=%b out_arvalid=%b, required all outputs 0",
                           out_bready, out_awvalid, out_arvalid);
    end
    ifu_arvalid = 1'b0; lsu_bready = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_awaddr = '0;
    @(negedge clock);
    reset = 1'b0; slv_hold_b = 1'b0;
    @(negedge clock);
    sb_ifu.push_back({2'b00, slave_data(32'h8000_0600)});
    ifu_read(32'h8000_0600, d, r, a, rc, to);
    exp = sb_ifu.pop_front();
    n_checks++;
    if (to || {r, d} !== exp) begin
      n_errors++; $display("FAIL read_after_reset: got to=%b resp=%b data=%h, required resp=%b data=%h",
                           to, r, d, exp[33:32], exp[31:0]);
    end
  endtask

  task automatic test_error_resp();
    logic [31:0] d; logic [1:0] r; int a, rc, a2, rc2; bit to; logic [33:0] exp;
    slv_rresp = 2'b10;
    sb_lsu.push_back({2'b10, slave_data(32'h8000_0700)});
    lsu_read(32'h8000_0700, d, r, a, rc, to);
    exp = sb_lsu.pop_front();
    n_checks++;
    if (to || {r, d} !== exp) begin
      n_errors++; $display("FAIL lsu_slverr: got to=%b resp=%b data=%h, required resp=%b data=%h",
                           to, r, d, exp[33:32], exp[31:0]);
    end
    slv_rresp = 2'b00;
    sb_ifu.push_back({2'b00, slave_data(32'h8000_0704)});
    ifu_read(32'h8000_0704, d, r, a2, rc2, to);
    exp = sb_ifu.pop_front();
    n_checks++;
    if (to || {r, d} !== exp || a2 - rc !== 2) begin
      n_errors++; $display("FAIL ifu_after_error: got to=%b data=%h gap=%0d, required data=%h gap=2",
                           to, d, a2 - rc, exp[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_contention();
    test_lsu_rd_wr();
    test_reset_mid_write();
    test_error_resp();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
